// File: rtl/fp16_norm_pkg.sv
// Shared types and constants for the fp16 post-add normalizer: FSM states,
// mantissa field positions and the 6-bit exponent add/sub helper.
package fp16_norm_pkg;

    localparam int EXP_W  = 6;
    localparam int MANT_W = 14;
    localparam int BIAS   = 15;

    localparam logic [4:0] EXP_INF = 5'h1F;

    // Mantissa layout: carry | hidden | 10-bit fraction | guard | sticky
    localparam int CARRY_BIT  = 13;
    localparam int HIDDEN_BIT = 12;
    localparam int FRAC_MSB   = 11;
    localparam int FRAC_LSB   = 2;
    localparam int GUARD_BIT  = 1;
    localparam int STICKY_BIT = 0;

    localparam logic             EXP_OP_ADD = 1'b0;
    localparam logic             EXP_OP_SUB = 1'b1;
    localparam logic [EXP_W-1:0] EXP_ONE    = 6'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ROUND,
        ST_OUT
    } state_e;

    // Exponent add/sub shared with the alignment stage; operands stay in 1..32.
    function automatic logic [EXP_W-1:0] exp_addsub(
        input logic [EXP_W-1:0] a,
        input logic [EXP_W-1:0] b,
        input logic             op
    );
        return op ? (a - b) : (a + b);
    endfunction

endpackage

// File: rtl/fp16_normalizer_seq.sv
// Sequential post-add normalizer: renormalizes one bit per cycle, rounds to
// nearest-even and packs an fp16 result behind valid/ready handshakes.
module fp16_normalizer_seq #(
    parameter int EXP_W  = fp16_norm_pkg::EXP_W,
    parameter int MANT_W = fp16_norm_pkg::MANT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_result,
    output logic              out_ovf,
    output logic              out_inexact
);

    import fp16_norm_pkg::*;

    state_e              state_q;
    logic                sign_q;
    logic [EXP_W-1:0]    exp_q;
    logic [MANT_W-1:0]   mant_q;
    logic                denorm_q;
    logic [15:0]         out_result_q;
    logic                ovf_q;
    logic                inexact_q;

    logic                round_up;
    logic [11:0]         sig12;
    logic                hidden;
    logic [9:0]          frac;
    logic [EXP_W-1:0]    exp_rnd;
    logic [EXP_W-1:0]    enc_exp;
    logic [15:0]         result_d;
    logic                ovf_d;
    logic                inexact_d;

    // Rounding datapath, consumed only in ROUND.
    always_comb begin
        round_up  = mant_q[GUARD_BIT] & (mant_q[STICKY_BIT] | mant_q[FRAC_LSB]);
        inexact_d = mant_q[GUARD_BIT] | mant_q[STICKY_BIT];
        sig12     = {1'b0, mant_q[HIDDEN_BIT:FRAC_LSB]} + {11'd0, round_up};
        exp_rnd   = exp_q;
        hidden    = sig12[10];
        frac      = sig12[9:0];
        if (sig12[11]) begin
            hidden  = 1'b1;
            frac    = '0;
            exp_rnd = exp_addsub(exp_q, EXP_ONE, EXP_OP_ADD);
        end
        // A denormal that rounds up into the hidden bit becomes the smallest normal.
        if (denorm_q) enc_exp = hidden ? EXP_ONE : '0;
        else          enc_exp = exp_rnd;
        ovf_d = (enc_exp >= {1'b0, EXP_INF});
        if (ovf_d) result_d = {sign_q, EXP_INF, 10'd0};
        else       result_d = {sign_q, enc_exp[4:0], frac};
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values and the block order cannot matter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mant_q       <= '0;
            denorm_q     <= 1'b0;
            out_result_q <= '0;
            ovf_q        <= 1'b0;
            inexact_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        exp_q    <= in_exp;
                        mant_q   <= in_mant;
                        denorm_q <= 1'b0;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (mant_q == '0) begin
                        denorm_q <= 1'b1;
                        state_q  <= ST_ROUND;
                    end else if (mant_q[CARRY_BIT]) begin
                        mant_q  <= {1'b0, mant_q[CARRY_BIT:2], mant_q[GUARD_BIT] | mant_q[STICKY_BIT]};
                        exp_q   <= exp_addsub(exp_q, EXP_ONE, EXP_OP_ADD);
                        state_q <= ST_ROUND;
                    end else if (mant_q[HIDDEN_BIT]) begin
                        state_q <= ST_ROUND;
                    end else if (exp_q <= EXP_ONE) begin
                        denorm_q <= 1'b1;
                        state_q  <= ST_ROUND;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_addsub(exp_q, EXP_ONE, EXP_OP_SUB);
                    end
                end
                ST_ROUND: begin
                    out_result_q <= result_d;
                    ovf_q        <= ovf_d;
                    inexact_q    <= inexact_d;
                    state_q      <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = rst_n && (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_OUT);
    assign out_result  = out_result_q;
    assign out_ovf     = ovf_q;
    assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fp16_normalizer_seq.sv
// Directed bench for fp16_normalizer_seq: vector table for results, flags and
// latency, plus hand sequences for backpressure, busy input and mid-op reset.
module tb_fp16_normalizer_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [5:0]  in_exp;
    logic [13:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_ovf;
    logic        out_inexact;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        sign;
        logic [5:0]  exp;
        logic [13:0] mant;
        logic [15:0] result;
        logic        ovf;
        logic        inexact;
        int          lat;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    fp16_normalizer_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_mant     (in_mant),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one operand at a negedge, then count edges until out_valid.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); @(negedge clk);
            waitc++;
        end
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, v.lat);
        check({tag, " result"}, {16'd0, out_result}, {16'd0, v.result});
        check({tag, " ovf"}, {31'd0, out_ovf}, {31'd0, v.ovf});
        check({tag, " inexact"}, {31'd0, out_inexact}, {31'd0, v.inexact});
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int accepts;
        int cyc;

        //          sign  exp    mant      result    ovf   inx   lat
        vecs[0]  = '{1'b0, 6'd15, 14'h1000, 16'h3C00, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 6'd15, 14'h2000, 16'h4000, 1'b0, 1'b0, 2};
        vecs[2]  = '{1'b0, 6'd30, 14'h2000, 16'h7C00, 1'b1, 1'b0, 2};
        vecs[3]  = '{1'b0, 6'd15, 14'h0400, 16'h3400, 1'b0, 1'b0, 4};
        vecs[4]  = '{1'b1, 6'd15, 14'h0000, 16'h8000, 1'b0, 1'b0, 2};
        vecs[5]  = '{1'b0, 6'd15, 14'h1FFE, 16'h4000, 1'b0, 1'b1, 2};
        vecs[6]  = '{1'b0, 6'd15, 14'h1002, 16'h3C00, 1'b0, 1'b1, 2};
        vecs[7]  = '{1'b0, 6'd15, 14'h1006, 16'h3C02, 1'b0, 1'b1, 2};
        vecs[8]  = '{1'b0, 6'd2,  14'h0400, 16'h0200, 1'b0, 1'b0, 3};
        vecs[9]  = '{1'b1, 6'd31, 14'h1000, 16'hFC00, 1'b1, 1'b0, 2};
        vecs[10] = '{1'b0, 6'd15, 14'h2003, 16'h4000, 1'b0, 1'b1, 2};
        vecs[11] = '{1'b0, 6'd1,  14'h0006, 16'h0002, 1'b0, 1'b1, 2};
        vecs[12] = '{1'b0, 6'd1,  14'h0FFE, 16'h0400, 1'b0, 1'b1, 2};
        vecs[13] = '{1'b0, 6'd20, 14'h0001, 16'h2000, 1'b0, 1'b0, 14};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_result", {16'd0, out_result}, 32'd0);
        check("rst out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst out_inexact", {31'd0, out_inexact}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Busy input held high plus 5 cycles of backpressure.
        in_sign  = 1'b0;
        in_exp   = 6'd15;
        in_mant  = 14'h1002;
        in_valid = 1'b1;
        accepts  = 0;
        cyc      = 0;
        while (!out_valid && cyc < 30) begin
            if (in_ready && in_valid) accepts++;
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        check("busy single accept", accepts, 1);
        check("busy out_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("bp%0d valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d result", k), {16'd0, out_result}, 32'h3C00);
            check($sformatf("bp%0d inexact", k), {31'd0, out_inexact}, 32'd1);
            check($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("bp release valid", {31'd0, out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while shifting: operand must vanish.
        in_exp   = 6'd15;
        in_mant  = 14'h0001;
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("midrst in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst release in_ready", {31'd0, in_ready}, 32'd1);
        accepts = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) accepts++;
            @(posedge clk); @(negedge clk);
        end
        check("midrst no output", accepts, 0);
        run_op(vecs[7], "after-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
